id_ex_operand_reg: RTL and testbench
====================================

# id_ex_operand_reg

ID/EX pipeline register that captures decoded operands and control for one instruction per cycle and drives the execute stage, including the 32-bit compare unit's `rs_1`, `rs_2` and `alu_ctrl` inputs. It applies EX/MEM and MEM/WB operand forwarding on its outputs. It also supports stall (hold) and flush (bubble insertion). While stalled, it refreshes held operands from MEM/WB so that results retiring during the stall are not lost.

## Interface
Parameters:
- `XLEN`, 32, operand width.
- `RA_W`, 5, register-address width.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID stage presents a valid instruction.
- `id_rs_1_data`, `id_rs_2_data` in XLEN: register-file read data.
- `id_rs_1_addr`, `id_rs_2_addr`, `id_rd_addr` in RA_W: source and destination register numbers.
- `id_alu_ctrl` in 4: ALU/compare opcode; `1000` = SLT, `1001` = SLTU.
- `id_reg_write` in 1: instruction writes `rd`.
- `stall` in 1: hold EX contents.
- `flush` in 1: kill EX contents.
- `exmem_reg_write` in 1, `exmem_rd_addr` in RA_W, `exmem_result` in XLEN: EX/MEM forwarding source.
- `memwb_reg_write` in 1, `memwb_rd_addr` in RA_W, `memwb_result` in XLEN: MEM/WB forwarding source.
- `rs_1`, `rs_2` out XLEN: forwarded operands to execute and the compare unit.
- `alu_ctrl` out 4: registered opcode.
- `ex_valid` out 1: EX slot holds a live instruction.
- `ex_rd_addr` out RA_W, `ex_reg_write` out 1: registered destination info.

## Operation
- Stored state: `v`, `op1`, `op2`, `a1`, `a2`, `rd`, `ctl`, `we`.
- Priority on each rising edge: reset > flush > stall > load.
  - Flush: `v`=0 and `we`=0; the other fields are don't-care but are held.
  - Stall (no flush): all fields held, except the refresh rule below.
  - Load: all fields captured from `id_*`; `v`=`id_valid`; `we`=`id_reg_write & id_valid`.
- Stall refresh: while `stall`=1 and `flush`=0, if `memwb_reg_write`=1, `memwb_rd_addr`==`a1` and `a1`!=0, then `op1` <= `memwb_result`. The same rule applies independently to `op2` with `a2`.
- Forwarding is combinational on the outputs, computed per operand:
  - If `exmem_reg_write`=1, `exmem_rd_addr`==`aN` and `aN`!=0, output `exmem_result`.
  - Else, if `memwb_reg_write`=1, `memwb_rd_addr`==`aN` and `aN`!=0, output `memwb_result`.
  - Else, output `opN`.
- Register x0 is never forwarded; a stored x0 operand is passed through as captured.
- Output mapping:
  - `ex_valid`=`v`.
  - `ex_reg_write`=`we & v`.
  - `alu_ctrl`=`ctl` regardless of `v`; downstream gates side effects with `ex_valid`.
- No arithmetic; widths pass through unchanged.

## Timing
- Latency: ID inputs appear on EX outputs one clock after a load edge.
- Forwarding path is zero-cycle (combinational from the `exmem_*` and `memwb_*` inputs).
- Reset (asynchronous assert, synchronous-to-clock release):
  - All state cleared to 0.
  - Outputs during reset: `rs_1`=`rs_2`=0 (addresses are 0, so no forwarding), `alu_ctrl`=0, `ex_valid`=0, `ex_rd_addr`=0, `ex_reg_write`=0.
- Reset mid-stall: state is cleared immediately; the first edge after release with `stall`=0 loads normally.
- Simultaneous stall and flush: flush wins, producing a bubble.
- Both forwarding sources match the same operand: EX/MEM wins.
- Both operands have the same address: both are forwarded identically.
- Stall with `id_valid`=1: ID inputs are ignored; ID is responsible for holding them.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle with non-zero state → all outputs 0 immediately, without waiting for a clock edge.
- Basic load and SLT:
  - Stimulus: load `id_rs_1_data`=0xFFFF_FFFF (a1=3), `id_rs_2_data`=1 (a2=4), `id_alu_ctrl`=1000, no forwarding matches.
  - Required: next cycle `rs_1`=0xFFFF_FFFF, `rs_2`=1, `alu_ctrl`=1000, `ex_valid`=1; compare unit downstream yields 1, and with `alu_ctrl`=1001 it yields 0.
- Forward priority:
  - Stimulus: a1=5 with `exmem_rd_addr`=5 (result 0xA) and `memwb_rd_addr`=5 (result 0xB), both write enables high.
  - Required: `rs_1`=0xA; dropping `exmem_reg_write` gives `rs_1`=0xB.
- x0 guard: a1=0 and `exmem_rd_addr`=0 with `exmem_reg_write`=1 → `rs_1` = captured value, not forwarded.
- Stall refresh:
  - Stimulus: stall 3 cycles with a2=7; in cycle 2 drive `memwb_rd_addr`=7, `memwb_result`=0x1234; then deassert all forwarding sources.
  - Required: `rs_2`=0x1234 for the remainder of the stall and after release.
- Flush vs stall:
  - Stimulus: `stall`=1 and `flush`=1 on the same edge with a valid instruction held.
  - Required: next cycle `ex_valid`=0 and `ex_reg_write`=0; the following load with `id_valid`=1 restores `ex_valid`=1.

Source files
------------

// File: rtl/id_ex_operand_reg.sv
// ----------------------------------------------------------------------------
// id_ex_operand_reg
//   ID/EX pipeline register. Captures one decoded instruction per cycle and
//   presents its operands to the execute stage and compare unit, with
//   EX/MEM and MEM/WB forwarding applied combinationally on the outputs.
//   Supports stall (hold, with MEM/WB refresh of held operands) and flush
//   (bubble insertion).
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   id_valid                        ID presents a valid instruction
//   id_rs_1_data, id_rs_2_data      register-file read data
//   id_rs_1_addr, id_rs_2_addr      source register numbers
//   id_rd_addr, id_reg_write        destination register / write enable
//   id_alu_ctrl                     ALU/compare opcode (1000 SLT, 1001 SLTU)
//   stall, flush                    hold / kill EX contents
//   exmem_reg_write/rd_addr/result  EX/MEM forwarding source
//   memwb_reg_write/rd_addr/result  MEM/WB forwarding source
//   rs_1, rs_2                      forwarded operands (combinational)
//   alu_ctrl                        registered opcode
//   ex_valid                        EX slot holds a live instruction
//   ex_rd_addr, ex_reg_write        registered destination info
// ----------------------------------------------------------------------------
module id_ex_operand_reg #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            id_valid,
    input  logic [XLEN-1:0] id_rs_1_data,
    input  logic [XLEN-1:0] id_rs_2_data,
    input  logic [RA_W-1:0] id_rs_1_addr,
    input  logic [RA_W-1:0] id_rs_2_addr,
    input  logic [RA_W-1:0] id_rd_addr,
    input  logic [3:0]      id_alu_ctrl,
    input  logic            id_reg_write,

    input  logic            stall,
    input  logic            flush,

    input  logic            exmem_reg_write,
    input  logic [RA_W-1:0] exmem_rd_addr,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RA_W-1:0] memwb_rd_addr,
    input  logic [XLEN-1:0] memwb_result,

    output logic [XLEN-1:0] rs_1,
    output logic [XLEN-1:0] rs_2,
    output logic [3:0]      alu_ctrl,
    output logic            ex_valid,
    output logic [RA_W-1:0] ex_rd_addr,
    output logic            ex_reg_write
);

    logic            v;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [RA_W-1:0] a1;
    logic [RA_W-1:0] a2;
    logic [RA_W-1:0] rd;
    logic [3:0]      ctl;
    logic            we;

    // MEM/WB hit per held source address; x0 never matches
    logic wb_hit_1;
    logic wb_hit_2;
    logic mem_hit_1;
    logic mem_hit_2;

    assign wb_hit_1  = memwb_reg_write && (memwb_rd_addr == a1) && (a1 != '0);
    assign wb_hit_2  = memwb_reg_write && (memwb_rd_addr == a2) && (a2 != '0);
    assign mem_hit_1 = exmem_reg_write && (exmem_rd_addr == a1) && (a1 != '0);
    assign mem_hit_2 = exmem_reg_write && (exmem_rd_addr == a2) && (a2 != '0);

    // Pipeline state: reset > flush > stall (with MEM/WB refresh) > load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v   <= 1'b0;
            op1 <= '0;
            op2 <= '0;
            a1  <= '0;
            a2  <= '0;
            rd  <= '0;
            ctl <= '0;
            we  <= 1'b0;
        end else if (flush) begin
            v  <= 1'b0;
            we <= 1'b0;
        end else if (stall) begin
            // Results retiring while held would otherwise be lost once
            // MEM/WB moves on, so fold them into the stored operands.
            if (wb_hit_1) op1 <= memwb_result;
            if (wb_hit_2) op2 <= memwb_result;
        end else begin
            v   <= id_valid;
            op1 <= id_rs_1_data;
            op2 <= id_rs_2_data;
            a1  <= id_rs_1_addr;
            a2  <= id_rs_2_addr;
            rd  <= id_rd_addr;
            ctl <= id_alu_ctrl;
            we  <= id_reg_write & id_valid;
        end
    end

    // Zero-cycle forwarding; EX/MEM is younger and takes priority
    always_comb begin
        rs_1 = op1;
        rs_2 = op2;
        if (mem_hit_1)     rs_1 = exmem_result;
        else if (wb_hit_1) rs_1 = memwb_result;
        if (mem_hit_2)     rs_2 = exmem_result;
        else if (wb_hit_2) rs_2 = memwb_result;
    end

    assign alu_ctrl     = ctl;
    assign ex_valid     = v;
    assign ex_rd_addr   = rd;
    assign ex_reg_write = we & v;

endmodule

// File: tb/tb_id_ex_operand_reg.sv
module tb_id_ex_operand_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_rs_1_data, id_rs_2_data;
    logic [4:0]  id_rs_1_addr, id_rs_2_addr, id_rd_addr;
    logic [3:0]  id_alu_ctrl;
    logic        id_reg_write;
    logic        stall, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd_addr, memwb_rd_addr;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] rs_1, rs_2;
    logic [3:0]  alu_ctrl;
    logic        ex_valid;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;

    always #5 clk = ~clk;

    id_ex_operand_reg dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid),
        .id_rs_1_data(id_rs_1_data), .id_rs_2_data(id_rs_2_data),
        .id_rs_1_addr(id_rs_1_addr), .id_rs_2_addr(id_rs_2_addr),
        .id_rd_addr(id_rd_addr), .id_alu_ctrl(id_alu_ctrl),
        .id_reg_write(id_reg_write),
        .stall(stall), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr),
        .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr),
        .memwb_result(memwb_result),
        .rs_1(rs_1), .rs_2(rs_2), .alu_ctrl(alu_ctrl), .ex_valid(ex_valid),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
    );

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctl;
        logic        v;
        logic [4:0]  rd;
        logic        we;
        logic        cmp;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: contents of the EX slot as an instruction record
    typedef struct {
        logic        live;
        logic [31:0] val1, val2;
        logic [4:0]  src1, src2, dst;
        logic [3:0]  op;
        logic        wr;
    } slot_t;
    slot_t m;

    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] held);
        if (a == 5'd0) return held;
        if (exmem_reg_write && exmem_rd_addr == a) return exmem_result;
        if (memwb_reg_write && memwb_rd_addr == a) return memwb_result;
        return held;
    endfunction

    function automatic logic compare(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        if (op == 4'b1000) return $signed(x) < $signed(y);
        if (op == 4'b1001) return x < y;
        return 1'b0;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.rs1 = operand(m.src1, m.val1);
        e.rs2 = operand(m.src2, m.val2);
        e.ctl = m.op;
        e.v   = m.live;
        e.rd  = m.dst;
        e.we  = m.live && m.wr;
        e.cmp = compare(m.op, e.rs1, e.rs2);
        return e;
    endfunction

    task automatic model_clear();
        m.live = 0; m.val1 = 0; m.val2 = 0; m.src1 = 0; m.src2 = 0;
        m.dst = 0; m.op = 0; m.wr = 0;
    endtask

    // What the clock edge does to the slot, given the inputs present at it
    task automatic model_edge();
        if (!rst_n) model_clear();
        else if (flush) begin
            m.live = 0; m.wr = 0;
        end else if (stall) begin
            if (memwb_reg_write && m.src1 != 0 && memwb_rd_addr == m.src1) m.val1 = memwb_result;
            if (memwb_reg_write && m.src2 != 0 && memwb_rd_addr == m.src2) m.val2 = memwb_result;
        end else begin
            m.live = id_valid;
            m.val1 = id_rs_1_data; m.val2 = id_rs_2_data;
            m.src1 = id_rs_1_addr; m.src2 = id_rs_2_addr;
            m.dst  = id_rd_addr;   m.op   = id_alu_ctrl;
            m.wr   = id_reg_write && id_valid;
        end
    endtask

    // Inputs are already driven: record this cycle's expectation, take the edge
    task automatic step();
        q.push_back(predict());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs_1_data = 0; id_rs_2_data = 0;
        id_rs_1_addr = 0; id_rs_2_addr = 0; id_rd_addr = 0;
        id_alu_ctrl = 0; id_reg_write = 0; stall = 0; flush = 0;
        exmem_reg_write = 0; exmem_rd_addr = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd_addr = 0; memwb_result = 0;
    endtask

    task automatic load(input logic [31:0] d1, input logic [4:0] s1,
                        input logic [31:0] d2, input logic [4:0] s2,
                        input logic [3:0] op);
        id_valid = 1; id_rs_1_data = d1; id_rs_1_addr = s1;
        id_rs_2_data = d2; id_rs_2_addr = s2; id_alu_ctrl = op;
        id_rd_addr = 5'd9; id_reg_write = 1;
    endtask

    // Assert reset between edges; outputs must clear before the next edge
    task automatic mid_cycle_reset();
        #1;
        rst_n = 0;
        model_clear();
        q.push_back(predict());
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic randomize_inputs();
        id_valid        = 1'($urandom_range(0, 3) != 0);
        id_rs_1_data    = $urandom;
        id_rs_2_data    = $urandom;
        id_rs_1_addr    = 5'($urandom_range(0, 7));
        id_rs_2_addr    = 5'($urandom_range(0, 7));
        id_rd_addr      = 5'($urandom);
        id_alu_ctrl     = 4'($urandom_range(7, 10));
        id_reg_write    = 1'($urandom);
        stall           = 1'($urandom_range(0, 2) == 0);
        flush           = 1'($urandom_range(0, 7) == 0);
        exmem_reg_write = 1'($urandom);
        exmem_rd_addr   = 5'($urandom_range(0, 7));
        exmem_result    = $urandom;
        memwb_reg_write = 1'($urandom);
        memwb_rd_addr   = 5'($urandom_range(0, 7));
        memwb_result    = $urandom;
    endtask

    // Monitor: compares the DUT against the oldest pending expectation
    initial begin
        exp_t e;
        logic c;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                c = compare(alu_ctrl, rs_1, rs_2);
                vectors++;
                if (rs_1 !== e.rs1 || rs_2 !== e.rs2 || alu_ctrl !== e.ctl ||
                    ex_valid !== e.v || ex_rd_addr !== e.rd ||
                    ex_reg_write !== e.we || c !== e.cmp) begin
                    miscompares++;
                    $display("FAIL vec%0d t=%0t: got rs_1=%h rs_2=%h ctl=%b v=%b rd=%0d we=%b cmp=%b, want rs_1=%h rs_2=%h ctl=%b v=%b rd=%0d we=%b cmp=%b",
                             vectors, $time, rs_1, rs_2, alu_ctrl, ex_valid, ex_rd_addr,
                             ex_reg_write, c, e.rs1, e.rs2, e.ctl, e.v, e.rd, e.we, e.cmp);
                end
            end
        end
    end

    initial begin
        int budget;
        rst_n = 0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        step();                 // outputs held at zero under reset
        rst_n = 1;

        // Basic load, SLT then SLTU on the same operands
        load(32'hFFFF_FFFF, 5'd3, 32'd1, 5'd4, 4'b1000);
        step();
        load(32'hFFFF_FFFF, 5'd3, 32'd1, 5'd4, 4'b1001);
        step();                 // shows SLT result, loads SLTU
        idle();
        step();                 // shows SLTU result

        // Forward priority on rs_1
        load(32'h0000_0077, 5'd5, 32'h0000_0066, 5'd6, 4'b0000);
        step();
        idle();
        stall = 1;
        exmem_reg_write = 1; exmem_rd_addr = 5'd5; exmem_result = 32'hA;
        memwb_reg_write = 1; memwb_rd_addr = 5'd5; memwb_result = 32'hB;
        step();
        exmem_reg_write = 0;
        step();

        // x0 is never forwarded
        idle();
        load(32'h0000_0055, 5'd0, 32'h0000_0044, 5'd0, 4'b1000);
        step();
        idle();
        stall = 1;
        exmem_reg_write = 1; exmem_rd_addr = 5'd0; exmem_result = 32'hDEAD;
        memwb_reg_write = 1; memwb_rd_addr = 5'd0; memwb_result = 32'hBEEF;
        step();

        // Stall refresh of rs_2 from MEM/WB
        idle();
        load(32'h1, 5'd1, 32'h9, 5'd7, 4'b1001);
        step();
        idle();
        stall = 1;
        step();
        memwb_reg_write = 1; memwb_rd_addr = 5'd7; memwb_result = 32'h1234;
        step();
        memwb_reg_write = 0; memwb_rd_addr = 0; memwb_result = 0;
        step();
        stall = 0;
        load(32'h2, 5'd2, 32'h3, 5'd3, 4'b1000);
        step();                 // still shows the refreshed operand

        // Stall and flush together make a bubble; next load revives the slot
        idle();
        stall = 1; flush = 1;
        step();
        stall = 0; flush = 0;
        load(32'h10, 5'd1, 32'h20, 5'd2, 4'b1001);
        step();
        idle();
        step();

        // Reset during a stall with a live instruction
        load(32'hCAFE, 5'd4, 32'hF00D, 5'd5, 4'b1000);
        step();
        idle();
        stall = 1;
        exmem_reg_write = 1; exmem_rd_addr = 5'd4; exmem_result = 32'h77;
        mid_cycle_reset();
        stall = 0;
        step();

        // Randomised traffic with occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            if (i % 97 == 50) mid_cycle_reset();
            else step();
        end

        idle();
        budget = 10;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
